mul_res_acc: RTL and testbench

Downstream consumer of the 32-bit multiplier result (calc_res). Accumulates a programmable number of products into a wide accumulator and presents one sum per block.
- Valid/ready handshake on the input and output sides.
- Saturating add with a sticky overflow flag.
- Sits between the shift-add multiplier and the result writeback/bus stage.

---
 rtl/mul_pkg.sv | 11 +
 rtl/mul_acc_sat.sv | 39 +++
 rtl/mul_res_acc.sv | 117 +++++++++++
 tb/tb_mul_res_acc.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared widths and accumulator state encoding for the multiplier datapath
// (multiplier, result accumulator, writeback stage).
package mul_pkg;

  localparam int unsigned PROD_W_DEF = 32;
  localparam int unsigned ACC_W_DEF  = 40;
  localparam int unsigned LEN_W_DEF  = 8;

  typedef enum logic {ACCUM, HOLD} acc_state_t;

endpackage

// File: rtl/mul_acc_sat.sv
// Combinational saturating adder: acc + product with an overflow flag.
// Unsigned by default; two's complement when MUL_RES_ACC_SIGNED_EN is defined.
module mul_acc_sat
  import mul_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  i_a,
  input  logic [PROD_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf
);

`ifdef MUL_RES_ACC_SIGNED_EN
  logic [ACC_W-1:0] w_b_ext;
  logic [ACC_W-1:0] w_raw;

  assign w_b_ext = {{(ACC_W-PROD_W){i_b[PROD_W-1]}}, i_b};
  assign w_raw   = i_a + w_b_ext;

  // Overflow only when both operands share a sign the result does not.
  assign o_ovf = (i_a[ACC_W-1] == w_b_ext[ACC_W-1]) &&
                 (w_raw[ACC_W-1] != i_a[ACC_W-1]);
  assign o_sum = !o_ovf       ? w_raw :
                 i_a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                {1'b0, {(ACC_W-1){1'b1}}};
`else
  logic [ACC_W:0] w_b_ext;
  logic [ACC_W:0] w_raw;

  assign w_b_ext = {{(ACC_W+1-PROD_W){1'b0}}, i_b};
  assign w_raw   = {1'b0, i_a} + w_b_ext;

  assign o_ovf = w_raw[ACC_W];
  assign o_sum = o_ovf ? {ACC_W{1'b1}} : w_raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/mul_res_acc.sv
// Accumulates acc_len multiplier products per block and presents one saturated
// sum per block. MUL_RES_ACC_SIGNED_EN selects two's complement arithmetic.
module mul_res_acc
  import mul_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_data,
  output logic              prod_ready,
  input  logic [LEN_W-1:0]  acc_len,
  input  logic              acc_clr,
  output logic              acc_valid,
  output logic [ACC_W-1:0]  acc_data,
  output logic              acc_ovf,
  input  logic              acc_ready
);

  localparam int unsigned CNT_W = LEN_W + 1;
  localparam logic [CNT_W-1:0] LEN_MAX = {1'b1, {LEN_W{1'b0}}};

  acc_state_t       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_acc_data;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len_q;
  logic             r_ovf;
  logic             r_acc_ovf;
  logic             r_acc_valid;
  logic             r_prod_ready;

  logic             w_accept;
  logic             w_first;
  logic [CNT_W-1:0] w_len_eff;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last;
  logic [ACC_W-1:0] w_sum;
  logic             w_sat_ovf;

  mul_acc_sat #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_sat (
    .i_a   (r_acc),
    .i_b   (prod_data),
    .o_sum (w_sum),
    .o_ovf (w_sat_ovf)
  );

  // The first beat of a block uses the live acc_len, later beats the sampled one.
  assign w_accept  = prod_valid && r_prod_ready;
  assign w_first   = (r_cnt == '0);
  assign w_len_eff = !w_first          ? r_len_q :
                     (acc_len == '0)   ? LEN_MAX : {1'b0, acc_len};
  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  assign w_last    = (w_cnt_nxt == w_len_eff);

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r_state      <= ACCUM;
      r_acc        <= '0;
      r_acc_data   <= '0;
      r_cnt        <= '0;
      r_len_q      <= '0;
      r_ovf        <= 1'b0;
      r_acc_ovf    <= 1'b0;
      r_acc_valid  <= 1'b0;
      r_prod_ready <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (acc_clr) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            r_prod_ready <= 1'b1;
          end else if (w_accept) begin
            if (w_first) r_len_q <= w_len_eff;
            r_acc        <= w_sum;
            r_cnt        <= w_cnt_nxt;
            r_ovf        <= r_ovf | w_sat_ovf;
            r_prod_ready <= !w_last;
            if (w_last) begin
              r_acc_data  <= w_sum;
              r_acc_ovf   <= r_ovf | w_sat_ovf;
              r_acc_valid <= 1'b1;
              r_state     <= HOLD;
            end
          end else begin
            r_prod_ready <= 1'b1;
          end
        end
        HOLD: begin
          // prod_ready stays low here, forcing a gap cycle before the next beat.
          if (acc_ready) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_acc_valid <= 1'b0;
            r_state     <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign prod_ready = r_prod_ready;
  assign acc_valid  = r_acc_valid;
  assign acc_data   = r_acc_data;
  assign acc_ovf    = r_acc_ovf;

endmodule

// File: tb/tb_mul_res_acc.sv
// Directed bench for mul_res_acc: two instances (ACC_W=40 and ACC_W=33) share
// stimulus; a width-generic reference model fills an expected-result queue.
module tb_mul_res_acc;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        prod_valid;
  logic [31:0] prod_data;
  logic [7:0]  acc_len;
  logic        acc_clr;
  logic        acc_ready;

  logic        prod_ready,   prod_ready33;
  logic        acc_valid,    acc_valid33;
  logic [39:0] acc_data;
  logic [32:0] acc_data33;
  logic        acc_ovf,      acc_ovf33;

  int checks = 0;
  int errors = 0;
  int waits;

  typedef struct {
    logic [63:0] d40;
    logic [63:0] d33;
    logic        o40;
    logic        o33;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] m_a40, m_a33;
  logic        m_o40, m_o33;
  int          m_cnt, m_len;

  always #5 clk = ~clk;

  mul_res_acc #(.PROD_W(32), .ACC_W(40), .LEN_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .prod_valid(prod_valid), .prod_data(prod_data),
    .prod_ready(prod_ready), .acc_len(acc_len), .acc_clr(acc_clr),
    .acc_valid(acc_valid), .acc_data(acc_data), .acc_ovf(acc_ovf),
    .acc_ready(acc_ready)
  );

  mul_res_acc #(.PROD_W(32), .ACC_W(33), .LEN_W(8)) dut33 (
    .clk(clk), .n_rst(n_rst), .prod_valid(prod_valid), .prod_data(prod_data),
    .prod_ready(prod_ready33), .acc_len(acc_len), .acc_clr(acc_clr),
    .acc_valid(acc_valid33), .acc_data(acc_data33), .acc_ovf(acc_ovf33),
    .acc_ready(acc_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference saturating add on a w-bit accumulator held in 64 bits.
  function automatic void madd(input int w, inout logic [63:0] a, inout logic ov,
                               input logic [31:0] b);
    logic [63:0] mask;
`ifdef MUL_RES_ACC_SIGNED_EN
    longint sa, sb_, s, mx, mn;
    mask = (64'd1 << w) - 64'd1;
    sa   = $signed(a << (64 - w)) >>> (64 - w);
    sb_  = longint'($signed(b));
    s    = sa + sb_;
    mx   = (longint'(1) <<< (w - 1)) - 1;
    mn   = -mx - 1;
    if (s > mx) begin s = mx; ov = 1'b1; end
    else if (s < mn) begin s = mn; ov = 1'b1; end
    a = 64'(s) & mask;
`else
    logic [63:0] s;
    mask = (64'd1 << w) - 64'd1;
    s    = a + {32'd0, b};
    if (s > mask) begin a = mask; ov = 1'b1; end
    else a = s;
`endif
  endfunction

  task automatic model_reset();
    m_a40 = '0; m_a33 = '0; m_o40 = 1'b0; m_o33 = 1'b0; m_cnt = 0;
  endtask

  task automatic model_beat();
    exp_t e;
    if (acc_clr) begin
      model_reset();
    end else begin
      if (m_cnt == 0) m_len = (acc_len == 8'd0) ? 256 : int'(acc_len);
      madd(40, m_a40, m_o40, prod_data);
      madd(33, m_a33, m_o33, prod_data);
      m_cnt++;
      if (m_cnt == m_len) begin
        e.d40 = m_a40; e.d33 = m_a33; e.o40 = m_o40; e.o33 = m_o33;
        sb.push_back(e);
        model_reset();
      end
    end
  endtask

  // One cycle: evaluate handshakes at the negedge, then advance to the next one.
  task automatic step();
    exp_t e;
    if (acc_valid && acc_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_spurious: got acc_valid=1 expected no pending result");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_data40", 64'(acc_data), e.d40);
        chk("sb_ovf40", 64'(acc_ovf), 64'(e.o40));
        chk("sb_valid33", 64'(acc_valid33), 64'd1);
        chk("sb_data33", 64'(acc_data33), e.d33);
        chk("sb_ovf33", 64'(acc_ovf33), 64'(e.o33));
      end
    end
    if (prod_valid && prod_ready) model_beat();
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] d, input logic clr);
    prod_valid = 1'b1; prod_data = d; acc_clr = clr; waits = 0;
    while (!prod_ready && waits < 50) begin
      step();
      waits++;
    end
    if (!prod_ready) chk("send_timeout", 64'(prod_ready), 64'd1);
    else step();
    prod_valid = 1'b0; acc_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    prod_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_prod_ready"}, 64'(prod_ready), 64'd0);
    chk({tag, "_acc_valid"}, 64'(acc_valid), 64'd0);
    chk({tag, "_acc_data"}, 64'(acc_data), 64'd0);
    chk({tag, "_acc_ovf"}, 64'(acc_ovf), 64'd0);
    chk({tag, "_acc_valid33"}, 64'(acc_valid33), 64'd0);
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic pulse_rst(input string tag);
    #2 n_rst = 1'b1;
    #1 chk_zero(tag);
    model_reset();
    sb.delete();
    @(negedge clk);
    n_rst = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; prod_valid = 1'b0; prod_data = '0; acc_len = '0;
    acc_clr = 1'b0; acc_ready = 1'b1;
    model_reset();
    m_len = 0;
    #1 n_rst = 1'b1;
    #1 chk_zero("reset");
    repeat (2) @(negedge clk);
    n_rst = 1'b0;

    // Basic block of four, then backpressure on the result.
    acc_len = 8'd4; acc_ready = 1'b0;
    send(32'd1, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      send(32'(i), 1'b0);
      chk("streaming_ready", 64'(waits), 64'd0);
    end
    chk("hold_valid", 64'(acc_valid), 64'd1);
    chk("hold_prod_ready", 64'(prod_ready), 64'd0);
    prod_valid = 1'b1; prod_data = 32'd99;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(acc_valid), 64'd1);
      chk("bp_prod_ready", 64'(prod_ready), 64'd0);
      chk("bp_data", 64'(acc_data), 64'd10);
      chk("bp_ovf", 64'(acc_ovf), 64'd0);
      step();
    end
    prod_valid = 1'b0; acc_ready = 1'b1;
    step();
    chk("release_valid", 64'(acc_valid), 64'd0);

    // 256-term block of all-ones products.
    acc_len = 8'd0; acc_ready = 1'b0;
    for (int i = 0; i < 256; i++) send(32'hFFFF_FFFF, 1'b0);
    chk("len256_valid", 64'(acc_valid), 64'd1);
    chk("len256_data", 64'(acc_data), 64'hFF_FFFF_FF00);
    chk("len256_ovf", 64'(acc_ovf), 64'd0);
    acc_ready = 1'b1;
    idle(2);

    acc_len = 8'd4; acc_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'hFFFF_FFFF, 1'b0);
`ifndef MUL_RES_ACC_SIGNED_EN
    chk("sat33_data", 64'(acc_data33), 64'h1_FFFF_FFFF);
    chk("sat33_ovf", 64'(acc_ovf33), 64'd1);
`endif
    acc_ready = 1'b1;
    idle(2);

    // Clear mid-block with a coincident beat, then clear during HOLD.
    acc_len = 8'd4;
    send(32'd5, 1'b0);
    send(32'd7, 1'b0);
    send(32'd9, 1'b1);
    for (int i = 0; i < 3; i++) send(32'd1, 1'b0);
    acc_ready = 1'b0;
    send(32'd1, 1'b0);
    acc_clr = 1'b1;
    idle(3);
    chk("clr_hold_valid", 64'(acc_valid), 64'd1);
    chk("clr_hold_data", 64'(acc_data), 64'd4);
    acc_clr = 1'b0; acc_ready = 1'b1;
    idle(2);

    // Reset mid-block, then mid-HOLD; no result may follow either.
    send(32'd3, 1'b0);
    send(32'd3, 1'b0);
    pulse_rst("rst_mid_block");
    idle(6);
    chk("rst_block_no_valid", 64'(acc_valid), 64'd0);
    acc_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'd2, 1'b0);
    idle(1);
    chk("pre_rst_hold_valid", 64'(acc_valid), 64'd1);
    pulse_rst("rst_mid_hold");
    acc_ready = 1'b1;
    idle(6);
    chk("rst_hold_no_valid", 64'(acc_valid), 64'd0);

    // Single-term blocks pass the product straight through.
    acc_len = 8'd1;
    send(32'h0000_1234, 1'b0);
    send(32'hDEAD_BEEF, 1'b0);
    idle(3);

`ifdef MUL_RES_ACC_SIGNED_EN
    acc_len = 8'd2; acc_ready = 1'b0;
    send(32'hFFFF_FFFF, 1'b0);
    send(32'h0000_0003, 1'b0);
    chk("signed_sum", 64'(acc_data), 64'd2);
    acc_ready = 1'b1;
    idle(2);
    acc_len = 8'd4; acc_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h8000_0000, 1'b0);
    chk("signed_sat33_data", 64'(acc_data33), 64'h1_0000_0000);
    chk("signed_sat33_ovf", 64'(acc_ovf33), 64'd1);
    acc_ready = 1'b1;
    idle(3);
`endif

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
